// File: rtl/seg_cnt_scan_if.sv
// Pin-level bundle for seg_cnt_scan: the control inputs and the counter/display outputs.
// The master drives the controls and the slave (the counter block) drives the counter and display outputs.
interface seg_cnt_scan_if #(
  parameter int DIGITS = 6
);
  logic                  en;
  logic                  mode;
  logic                  dir;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   num;
  logic                  carry;
  logic [DIGITS-1:0]     sel;
  logic [7:0]            seg;

  modport master (
    output en, mode, dir, load, load_val,
    input  num, carry, sel, seg
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output num, carry, sel, seg
  );
endinterface

// File: rtl/seg_cnt_scan.sv
// Hex/BCD up/down counter stepped by a prescaled tick, driving a multiplexed 7-seg display; outputs registered, 1-cycle latency.
// No backpressure (pins only). Define SEG_CNT_LZB_EN to blank leading-zero digits.
module seg_cnt_scan #(
  parameter int                DIGITS      = 6,
  parameter logic [4*DIGITS-1:0] INIT_VAL  = 'h1314,
  parameter int                INC_TIME    = 3_000_000,
  parameter int                STAY_TIME   = 50_000,
  parameter bit                SEL_ACT_LOW = 1'b1,
  parameter bit                SEG_ACT_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_cnt_scan_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = (INC_TIME  > 1) ? $clog2(INC_TIME)  : 1;
  localparam int SW = (STAY_TIME > 1) ? $clog2(STAY_TIME) : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam logic [PW-1:0]     PRE_LAST  = PW'(INC_TIME - 1);
  localparam logic [SW-1:0]     SCAN_LAST = SW'(STAY_TIME - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [W-1:0]      num_q, num_base, load_eff, num_step;
  logic              carry_q, tick, ripple;
  logic [3:0]        dig_max, cur_dig;
  logic [PW-1:0]     pre_q;
  logic [SW-1:0]     scan_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] sel_q, sel_hot;
  logic [7:0]        seg_q, seg_hot;
  logic              blank;

  assign tick    = bus.en && (pre_q == PRE_LAST);
  assign dig_max = bus.mode ? 4'd9 : 4'd15;

  // Decimal mode forces out-of-range digits to 9, both on the held value and on loads.
  always_comb begin
    num_base = num_q;
    load_eff = bus.load_val;
    if (bus.mode) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (num_q[4*i +: 4] > 4'd9)        num_base[4*i +: 4] = 4'd9;
        if (bus.load_val[4*i +: 4] > 4'd9) load_eff[4*i +: 4] = 4'd9;
      end
    end
  end

  // Single-cycle ripple: a digit only moves while every lower digit rolled over.
  always_comb begin
    num_step = num_base;
    ripple   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ripple) begin
        if (!bus.dir) begin
          if (num_base[4*i +: 4] == dig_max) begin
            num_step[4*i +: 4] = 4'd0;
          end else begin
            num_step[4*i +: 4] = num_base[4*i +: 4] + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (num_base[4*i +: 4] == 4'd0) begin
            num_step[4*i +: 4] = dig_max;
          end else begin
            num_step[4*i +: 4] = num_base[4*i +: 4] - 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q   <= INIT_VAL;
      carry_q <= 1'b0;
      pre_q   <= '0;
    end else begin
      carry_q <= 1'b0;
      if (bus.load) begin
        num_q <= load_eff;
        pre_q <= '0;
      end else begin
        if (bus.en) pre_q <= tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          num_q   <= num_step;
          carry_q <= ripple;
        end else begin
          num_q   <= num_base;
        end
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;  4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;  4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;  4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;  4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

`ifdef SEG_CNT_LZB_EN
  // Blank a digit when it and everything above it are zero; digit 0 is never blanked.
  assign blank = (idx_q != '0) && ((num_q >> {idx_q, 2'b00}) == '0);
`else
  assign blank = 1'b0;
`endif

  assign cur_dig = num_q[4*idx_q +: 4];
  assign sel_hot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
  assign seg_hot = blank ? 8'h00 : {1'b0, decode(cur_dig)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      sel_q  <= SEL_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      if (scan_q == SCAN_LAST) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      sel_q <= sel_hot ^ SEL_OFF;
      seg_q <= seg_hot ^ SEG_OFF;
    end
  end

  assign bus.num   = num_q;
  assign bus.carry = carry_q;
  assign bus.sel   = sel_q;
  assign bus.seg   = seg_q;
endmodule
